// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential WIDTH x WIDTH multiplier. It retires one multiplier bit per clock
//   (shift-and-add) and stops as soon as the remaining multiplier bits are zero.
//   Signed operands are handled as sign-magnitude: the magnitudes are multiplied
//   and the product is negated once at the end.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands a, b, signed_mode are valid
//   in_ready     operands accepted (high only in IDLE)
//   a, b         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   out_valid    product valid, held until out_ready
//   out_ready    consumer accepts product
//   product      2*WIDTH-bit result
//   busy         high while RUN or DONE
//   cycles       RUN iterations used for the current or last product
module shift_add_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [CW-1:0]        cycles
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   product_q;
  logic [WIDTH-1:0] mplier_q;
  logic            neg_q;
  logic [CW-1:0]   cycles_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic             neg_d;
  logic [PW-1:0]    acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic [PW-1:0]    product_d;

  // Operand magnitudes. Negating the most-negative value wraps back to the
  // same bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    mag_a_d   = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b_d   = (signed_mode && b[WIDTH-1]) ? -b : b;
    neg_d     = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_d  = mplier_q >> 1;
    product_d = neg_q ? -acc_d : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      cycles_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q   <= mag_b_d;
            acc_q      <= '0;
            neg_q      <= neg_d;
            cycles_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (mag_b_d == '0) begin
              // Nothing to iterate: the result is known at accept time.
              product_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cycles_q <= cycles_q + CW'(1);
          // Early exit once no set multiplier bits remain.
          if (mplier_d == '0) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Directed vectors and corner sequences on a WIDTH=8 instance, plus random
//   sweeps on WIDTH=4, 8 and 16 instances against an arithmetic reference.
module tb_shift_add_multiplier;

  logic clk;
  logic rst_n;
  logic rst_sweep_n;

  int n_checks;
  int n_fail;
  int sweeps_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- WIDTH=8 instance for directed tests ----------------
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;
  logic [3:0]  cycles;

  shift_add_multiplier #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy),
    .cycles     (cycles)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
    int          c;
  } vec_t;

  vec_t vecs[9];

  // Runs one operation; lat counts clock edges from the accept edge (inclusive)
  // up to the edge after which out_valid is seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                        input int stall, output logic [15:0] p, output int c,
                        output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a = ta;
    b = tb_v;
    signed_mode = tsm;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
    repeat (stall) @(negedge clk);
    p = product;
    c = int'(cycles);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [15:0] p;
    int          c;
    int          lat;
    int          guard;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'd143,   4};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'd65025, 8};
    vecs[2] = '{8'd77,  8'd0,   1'b0, 16'd0,     0};
    vecs[3] = '{8'd77,  8'd1,   1'b0, 16'd77,    1};
    vecs[4] = '{8'h80,  8'h80,  1'b1, 16'd16384, 8};
    vecs[5] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1,  3};
    // b = -1 has magnitude 1, so only one iteration is needed.
    vecs[6] = '{8'd127, 8'hFF,  1'b1, 16'hFF81,  1};
    vecs[7] = '{8'h80,  8'hFF,  1'b0, 16'd32640, 8};
    vecs[8] = '{8'hFF,  8'h80,  1'b1, 16'd128,   8};

    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    n_checks = 0;
    n_fail = 0;
    sweeps_done = 0;
    rst_n = 1'b0;
    rst_sweep_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_product", product, 0);
    check("reset_cycles", cycles, 0);
    rst_n = 1'b1;
    rst_sweep_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, i % 3, p, c, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].p);
      check($sformatf("vec%0d_cycles", i), c, vecs[i].c);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].c + 1);
    end

    // Back-pressure: DONE must hold and ignore operand traffic.
    @(negedge clk);
    a = 8'd13;
    b = 8'd11;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_product", product, 143);
      check("bp_cycles", cycles, 4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("idle_product_retained", product, 143);
    run_op(8'd6, 8'd7, 1'b0, 0, p, c, lat);
    check("after_bp_product", p, 42);
    check("after_bp_cycles", c, 3);

    // Reset during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'd200;
    b = 8'd255;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid_after", out_valid, 0);
    run_op(8'd3, 8'd5, 1'b0, 1, p, c, lat);
    check("after_abort_product", p, 15);
    check("after_abort_cycles", c, 3);

    guard = 0;
    while (sweeps_done < 3 && guard < 80000) begin
      @(negedge clk);
      guard++;
    end
    check("sweeps_finished", sweeps_done, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- random sweeps on several widths ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W   = (gi == 0) ? 4 : ((gi == 1) ? 8 : 16);
    localparam int PW  = 2 * W;
    localparam int SCW = $clog2(W + 1);

    logic           s_in_valid, s_in_ready, s_sm, s_out_valid, s_out_ready, s_busy;
    logic [W-1:0]   s_a, s_b;
    logic [PW-1:0]  s_product;
    logic [SCW-1:0] s_cycles;

    shift_add_multiplier #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_sweep_n),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .a          (s_a),
      .b          (s_b),
      .signed_mode(s_sm),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .product    (s_product),
      .busy       (s_busy),
      .cycles     (s_cycles)
    );

    initial begin
      logic [W-1:0]  ra, rb;
      logic          rsm;
      longint        sa, sb, mb;
      logic [PW-1:0] pe;
      int            ce, lat, stall;

      s_in_valid = 1'b0;
      s_out_ready = 1'b0;
      s_a = '0;
      s_b = '0;
      s_sm = 1'b0;
      @(negedge clk);
      while (rst_sweep_n !== 1'b1) @(negedge clk);

      for (int n = 0; n < 1000; n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if (n % 8 == 0) rb = W'($urandom_range(0, 2));
        rsm = 1'($urandom_range(0, 1));
        // Reference: plain integer multiply of the operands as interpreted.
        sa = rsm ? longint'($signed(ra)) : longint'(ra);
        sb = rsm ? longint'($signed(rb)) : longint'(rb);
        pe = PW'(sa * sb);
        mb = (sb < 0) ? -sb : sb;
        ce = 0;
        while (mb != 0) begin
          mb = mb / 2;
          ce++;
        end
        stall = $urandom_range(0, 3);

        @(negedge clk);
        check($sformatf("w%0d_in_ready", W), s_in_ready, 1);
        s_a = ra;
        s_b = rb;
        s_sm = rsm;
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 2 * W + 8) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("w%0d_latency", W), lat, ce + 1);
        repeat (stall) @(negedge clk);
        check($sformatf("w%0d_product a=%0h b=%0h s=%0d", W, ra, rb, rsm), s_product, pe);
        check($sformatf("w%0d_cycles", W), s_cycles, ce);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
      end
      sweeps_done++;
    end
  end

endmodule
